cdr_phase_detector: RTL and testbench

Early/late phase detector for the chip-rate clock-data-recovery loop. Samples the asynchronous demodulated chip stream at the early, mid and late strobes of the CDR counter, recovers the chip value, and produces the transition flag (T) and early/late flag (E) consumed by the period divider that trims the sampling period by ±2 clock periods. Runs on the 50 MHz system clock, posedge. T/E are therefore stable when the divider samples them on the negedge.

---
 rtl/cdr_pkg.sv | 16 +
 rtl/cdr_phase_detector_if.sv | 39 +++
 rtl/cdr_pd_vote.sv | 58 +++++
 rtl/cdr_phase_detector.sv | 109 ++++++++++
 tb/tb_cdr_phase_detector.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdr_pkg.sv
// Shared types and constants for the CDR early/late phase detector.
// Decision bundle, reset values and default vote-filter sizing.
package cdr_pkg;

    typedef struct packed {
        logic t;
        logic e;
    } pd_dec_t;

    localparam pd_dec_t PD_DEC_RST = '{t: 1'b0, e: 1'b0};
    localparam logic    PD_CHIP_RST = 1'b0;

    localparam int PD_VOTE_WIN_DEF = 8;
    localparam int PD_VOTE_TH_DEF  = 3;

endpackage

// File: rtl/cdr_phase_detector_if.sv
// Strobe, chip-stream and decision signals of the phase detector.
// slave is the detector side, master the CDR counter / divider side.
interface cdr_phase_detector_if;

    logic i_rx;
    logic i_en_d;
    logic i_en_m;
    logic i_en_f;
    logic o_T;
    logic o_E;
    logic o_chip;
    logic o_chip_valid;
    logic o_win_err;

    modport slave (
        input  i_rx,
        input  i_en_d,
        input  i_en_m,
        input  i_en_f,
        output o_T,
        output o_E,
        output o_chip,
        output o_chip_valid,
        output o_win_err
    );

    modport master (
        output i_rx,
        output i_en_d,
        output i_en_m,
        output i_en_f,
        input  o_T,
        input  o_E,
        input  o_chip,
        input  o_chip_valid,
        input  o_win_err
    );

endinterface

// File: rtl/cdr_pd_vote.sv
// Vote filter: accumulates early/late votes over valid windows and fires
// a correction when the net count reaches VOTE_TH within VOTE_WIN windows.
module cdr_pd_vote
    import cdr_pkg::*;
#(
    parameter int VOTE_WIN = PD_VOTE_WIN_DEF,
    parameter int VOTE_TH  = PD_VOTE_TH_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic win_i,
    input  logic t_i,
    input  logic e_i,
    output logic fire_o,
    output logic dir_o
);

    localparam int AW = $clog2(VOTE_WIN) + 2;
    localparam int CW = $clog2(VOTE_WIN + 1);

    // acc is two's complement; magnitude never exceeds VOTE_TH
    logic [AW-1:0] acc_q, acc_d, acc_nx, acc_mag;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nx;

    always_comb begin
        acc_nx = acc_q;
        if (t_i) begin
            acc_nx = e_i ? acc_q + AW'(1) : acc_q - AW'(1);
        end
        acc_mag = acc_nx[AW-1] ? (~acc_nx + AW'(1)) : acc_nx;
        cnt_nx  = cnt_q + CW'(1);
        fire_o  = win_i && (acc_mag >= AW'(VOTE_TH));
        dir_o   = !acc_nx[AW-1] && (acc_nx != '0);

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (win_i) begin
            if (fire_o || (cnt_nx == CW'(VOTE_WIN))) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_nx;
                cnt_d = cnt_nx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cdr_phase_detector.sv
// Early/late phase detector for the chip-rate CDR loop.
// Define CDR_PD_VOTE_EN to add the cdr_pd_vote filter on T/E.
module cdr_phase_detector
    import cdr_pkg::*;
#(
    parameter int VOTE_WIN = PD_VOTE_WIN_DEF,
    parameter int VOTE_TH  = PD_VOTE_TH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    cdr_phase_detector_if.slave   pd
);

    if (VOTE_WIN < 2 || VOTE_TH < 1 || VOTE_TH > VOTE_WIN) begin : g_bad_cfg
        $error("cdr_phase_detector: bad VOTE_WIN/VOTE_TH");
    end

    logic    rx_meta_q, rx_s_q;
    logic    got_d_q, got_m_q;
    logic    s_d_q, s_m_q;
    logic    chip_q, chip_vld_q, win_err_q;
    pd_dec_t dec_q, dec_d, raw;
    logic    have_d, have_m, sd_eff, sm_eff, win_ok;

    // Strobes coincident with i_en_f count as present and see this rx_s
    assign have_d = got_d_q | pd.i_en_d;
    assign have_m = got_m_q | pd.i_en_m;
    assign sd_eff = pd.i_en_d ? rx_s_q : s_d_q;
    assign sm_eff = pd.i_en_m ? rx_s_q : s_m_q;
    assign win_ok = pd.i_en_f & have_d & have_m;

    assign raw.t = sd_eff ^ rx_s_q;
    assign raw.e = (sd_eff == sm_eff);

`ifdef CDR_PD_VOTE_EN
    logic vote_fire, vote_dir;

    cdr_pd_vote #(
        .VOTE_WIN (VOTE_WIN),
        .VOTE_TH  (VOTE_TH)
    ) u_vote (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .win_i  (win_ok),
        .t_i    (raw.t),
        .e_i    (raw.e),
        .fire_o (vote_fire),
        .dir_o  (vote_dir)
    );

    always_comb begin
        dec_d = dec_q;
        if (pd.i_en_f) begin
            dec_d.t = win_ok & vote_fire;
            if (win_ok && vote_fire) begin
                dec_d.e = vote_dir;
            end
        end
    end
`else
    always_comb begin
        dec_d = dec_q;
        if (pd.i_en_f) begin
            if (win_ok) begin
                dec_d = raw;
            end else begin
                dec_d.t = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_q  <= 1'b0;
            rx_s_q     <= 1'b0;
            got_d_q    <= 1'b0;
            got_m_q    <= 1'b0;
            s_d_q      <= 1'b0;
            s_m_q      <= 1'b0;
            chip_q     <= PD_CHIP_RST;
            chip_vld_q <= 1'b0;
            win_err_q  <= 1'b0;
            dec_q      <= PD_DEC_RST;
        end else begin
            rx_meta_q  <= pd.i_rx;
            rx_s_q     <= rx_meta_q;
            if (pd.i_en_d) begin
                s_d_q <= rx_s_q;
            end
            if (pd.i_en_m) begin
                s_m_q  <= rx_s_q;
                chip_q <= rx_s_q;
            end
            chip_vld_q <= pd.i_en_m;
            win_err_q  <= pd.i_en_f & ~win_ok;
            got_d_q    <= pd.i_en_f ? 1'b0 : have_d;
            got_m_q    <= pd.i_en_f ? 1'b0 : have_m;
            dec_q      <= dec_d;
        end
    end

    assign pd.o_T          = dec_q.t;
    assign pd.o_E          = dec_q.e;
    assign pd.o_chip       = chip_q;
    assign pd.o_chip_valid = chip_vld_q;
    assign pd.o_win_err    = win_err_q;

endmodule

// File: tb/tb_cdr_phase_detector.sv
// Self-checking bench for cdr_phase_detector: vector table plus corner
// sequences, with queued expectations for decisions and recovered chips.
module tb_cdr_phase_detector;

    typedef struct packed {
        logic t;
        logic e;
        logic err;
    } dec_exp_t;

    typedef struct packed {
        logic rd;
        logic rm;
        logic rf;
        logic t;
        logic e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic last_e = 1'b0;

    dec_exp_t dec_q[$];
    logic     chip_q[$];

    cdr_phase_detector_if pd_if ();

    cdr_phase_detector dut (
        .i_clk (clk),
        .i_rst (rst),
        .pd    (pd_if)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (pd_if.o_chip_valid === 1'b1) begin
            if (chip_q.size() == 0) begin
                chk("chip_unexpected", 1'b1, 1'b0);
            end else begin
                chk("chip", pd_if.o_chip, chip_q.pop_front());
            end
        end
    end

    task automatic exp_ok(input logic t, input logic e);
        dec_q.push_back('{t: t, e: e, err: 1'b0});
        last_e = e;
    endtask

    task automatic exp_err();
        dec_q.push_back('{t: 1'b0, e: last_e, err: 1'b1});
    endtask

    // Settle rx through the synchronizer, then pulse the given strobes
    task automatic step(input logic rx, input logic d, input logic m, input logic f);
        dec_exp_t x;
        pd_if.i_rx = rx;
        repeat (3) tick();
        pd_if.i_en_d = d;
        pd_if.i_en_m = m;
        pd_if.i_en_f = f;
        if (m) chip_q.push_back(rx);
        tick();
        pd_if.i_en_d = 1'b0;
        pd_if.i_en_m = 1'b0;
        pd_if.i_en_f = 1'b0;
        if (f) begin
            if (dec_q.size() == 0) begin
                chk("dec_queue_empty", 1'b1, 1'b0);
            end else begin
                x = dec_q.pop_front();
                chk("T", pd_if.o_T, x.t);
                chk("E", pd_if.o_E, x.e);
                chk("win_err", pd_if.o_win_err, x.err);
            end
        end
    endtask

    task automatic win(input logic rd, input logic rm, input logic rf);
        step(rd, 1'b1, 1'b0, 1'b0);
        step(rm, 1'b0, 1'b1, 1'b0);
        step(rf, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            pd_if.i_en_d = i[0];
            pd_if.i_en_m = ~i[0];
            pd_if.i_en_f = 1'b1;
            pd_if.i_rx   = i[0];
            tick();
        end
        pd_if.i_en_d = 1'b0;
        pd_if.i_en_m = 1'b0;
        pd_if.i_en_f = 1'b0;
        rst = 1'b1;
        last_e = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{rd: 0, rm: 1, rf: 1, t: 1, e: 0};
        tbl[1] = '{rd: 0, rm: 0, rf: 1, t: 1, e: 1};
        tbl[2] = '{rd: 1, rm: 1, rf: 1, t: 0, e: 1};
        tbl[3] = '{rd: 1, rm: 0, rf: 0, t: 1, e: 0};
        tbl[4] = '{rd: 1, rm: 1, rf: 0, t: 1, e: 1};
        tbl[5] = '{rd: 0, rm: 0, rf: 0, t: 0, e: 1};
        tbl[6] = '{rd: 0, rm: 1, rf: 0, t: 0, e: 0};
        tbl[7] = '{rd: 1, rm: 0, rf: 1, t: 0, e: 0};

        pd_if.i_rx   = 1'b0;
        pd_if.i_en_d = 1'b0;
        pd_if.i_en_m = 1'b0;
        pd_if.i_en_f = 1'b0;
        rst = 1'b0;

        do_reset(3);
        rst = 1'b0;
        chk("rst_T", pd_if.o_T, 1'b0);
        chk("rst_E", pd_if.o_E, 1'b0);
        chk("rst_chip", pd_if.o_chip, 1'b0);
        chk("rst_chip_valid", pd_if.o_chip_valid, 1'b0);
        chk("rst_win_err", pd_if.o_win_err, 1'b0);
        rst = 1'b1;

        exp_err();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("win_err_pulse_end", pd_if.o_win_err, 1'b0);

`ifndef CDR_PD_VOTE_EN
        for (int i = 0; i < 8; i++) begin
            exp_ok(tbl[i].t, tbl[i].e);
            win(tbl[i].rd, tbl[i].rm, tbl[i].rf);
        end

        // Early edge then constant rx: T drops, E follows e
        exp_ok(1'b1, 1'b1);
        win(1'b0, 1'b0, 1'b1);
        exp_ok(1'b0, 1'b1);
        win(1'b1, 1'b1, 1'b1);

        // Missing mid strobe
        exp_err();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok(1'b1, 1'b0);
        win(1'b0, 1'b1, 1'b1);

        // Missing early strobe
        exp_err();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // All strobes in one cycle
        exp_ok(1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // Mid and late together
        exp_ok(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);

        // Repeated early strobe overwrites its sample
        exp_ok(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset between mid and late discards the window
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        do_reset(2);
        chk("midrst_T", pd_if.o_T, 1'b0);
        chk("midrst_E", pd_if.o_E, 1'b0);
        exp_err();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok(1'b1, 1'b0);
        win(1'b0, 1'b1, 1'b1);
`else
        // Three early windows fire only at the third close
        exp_ok(1'b0, 1'b0);
        win(1'b0, 1'b0, 1'b1);
        exp_ok(1'b0, 1'b0);
        win(1'b0, 1'b0, 1'b1);
        exp_ok(1'b1, 1'b1);
        win(1'b0, 1'b0, 1'b1);

        // Seven alternating windows leave acc=+1, eighth closes the epoch
        for (int i = 0; i < 7; i++) begin
            exp_ok(1'b0, 1'b1);
            if (i[0]) win(1'b0, 1'b1, 1'b1);
            else      win(1'b0, 1'b0, 1'b1);
        end
        exp_ok(1'b0, 1'b1);
        win(1'b1, 1'b1, 1'b1);

        // A cleared acc needs three fresh late windows
        exp_ok(1'b0, 1'b1);
        win(1'b0, 1'b1, 1'b1);
        exp_err();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok(1'b0, 1'b1);
        win(1'b0, 1'b1, 1'b1);
        exp_ok(1'b1, 1'b0);
        win(1'b0, 1'b1, 1'b1);
`endif

        repeat (3) tick();
        chk("chip_queue_drained", chip_q.size() == 0, 1'b1);
        chk("dec_queue_drained", dec_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
